// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-port register file.
package reg_file_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W_DEF   = 32;
  localparam int RF_DEPTH_DEF    = 32;
  localparam int RF_NUM_RD_DEF   = 2;
  localparam int RF_ZERO_REG_DEF = 1;
  localparam int RF_BYPASS_DEF   = 1;

  // Address width for a given register count.
  function automatic int rf_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Clear engine: sweeps every register to zero after reset or on request,
// flags writes that arrive while the sweep is running.
module reg_file_clear_fsm
  import reg_file_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH_DEF,
  parameter int ADDR_W = rf_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              reg_write,
  output logic              clear_busy,
  output logic              write_err,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output rf_state_e         state
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // State, sweep pointer and the write-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RF_CLEAR;
      ptr_q     <= '0;
      write_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      write_err <= reg_write && (state_q == RF_CLEAR);
    end
  end

  // Next state: a sweep runs to the last register and cannot be restarted.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      RF_IDLE: begin
        if (clear_req) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
      RF_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RF_IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign clear_busy = (state_q == RF_CLEAR);
  assign clr_we     = (state_q == RF_CLEAR);
  assign clr_addr   = ptr_q;
  assign state      = state_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with optional zero register, optional
// write-to-read bypass and a sequential clear engine.
// Handshake: none; writes take effect on the rising edge when regWrite is
// high and the clear engine is idle, reads are purely combinational.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W_DEF,
  parameter  int DEPTH    = RF_DEPTH_DEF,
  parameter  int NUM_RD   = RF_NUM_RD_DEF,
  parameter  int ZERO_REG = RF_ZERO_REG_DEF,
  parameter  int BYPASS   = RF_BYPASS_DEF,
  localparam int ADDR_W   = rf_addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic                     write_err,
  input  logic                     regWrite,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*DATA_W-1:0] read_data
);

  logic [DATA_W-1:0] regmem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  rf_state_e         state;
  logic              wr_zero;
  logic              wr_en;

  reg_file_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .reg_write  (regWrite),
    .clear_busy (clear_busy),
    .write_err  (write_err),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr),
    .state      (state)
  );

  assign wr_zero = (ZERO_REG != 0) && (write_reg == '0);
  assign wr_en   = regWrite && (state == RF_IDLE) && !wr_zero;

  // Array write port: the sweep owns the port while it runs.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regmem[clr_addr] <= '0;
    end else if (wr_en) begin
      regmem[write_reg] <= write_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rval;

    assign raddr = read_reg[p*ADDR_W +: ADDR_W];

    // Read mux: busy blanks everything, zero register next, then bypass.
    always_comb begin
      rval = regmem[raddr];
      if (clear_busy) begin
        rval = '0;
      end else if ((ZERO_REG != 0) && (raddr == '0)) begin
        rval = '0;
      end else if ((BYPASS != 0) && wr_en && (write_reg == raddr)) begin
        rval = write_data;
      end
    end

    assign read_data[p*DATA_W +: DATA_W] = rval;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: dut_a uses the defaults (zero register,
// bypass), dut_b disables both; they share all inputs.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear_req;
  logic          regWrite;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [2*AW-1:0] read_reg;

  logic          busy_a, busy_b, err_a, err_b;
  logic [2*DW-1:0] rd_a, rd_b;

  int checks = 0;
  int errors = 0;

  // Clock and reset block
  always #5 clk = ~clk;

  reg_file_mp dut_a (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(busy_a),
    .write_err(err_a), .regWrite(regWrite), .write_reg(write_reg),
    .write_data(write_data), .read_reg(read_reg), .read_data(rd_a)
  );

  reg_file_mp #(.ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_busy(busy_b),
    .write_err(err_b), .regWrite(regWrite), .write_reg(write_reg),
    .write_data(write_data), .read_reg(read_reg), .read_data(rd_b)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    read_reg = {AW'(a1), AW'(a0)};
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts busy cycles from now; optionally re-requests clear at busy cycle 10.
  task automatic count_busy(output int cnt, input bit poke);
    cnt = 0;
    while (busy_a && cnt < 100) begin
      cnt++;
      if (rd_a != '0 || rd_b != '0) chk("read_zero_busy", rd_a[DW-1:0] | rd_b[DW-1:0], '0);
      clear_req = poke && (cnt == 10);
      tick();
    end
    clear_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      set_rd(i, 31 - i);
      if (rd_a != '0 || rd_b != '0) bad++;
    end
    chk(tag, bad, 0);
  endtask

  int cnt;

  initial begin
    reset = 1'b0; clear_req = 1'b0; regWrite = 1'b0;
    write_reg = '0; write_data = '0; read_reg = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset_busy", busy_a, 1'b1);
    chk("reset_err", err_a, 1'b0);
    tick(); tick();
    reset = 1'b0;

    // 1. sweep after reset release
    set_rd(7, 3);
    count_busy(cnt, 1'b0);
    chk("reset_sweep_len", cnt, 32);
    chk("busy_b_after", busy_b, 1'b0);
    check_all_zero("post_reset_zero");

    // 2. write r5 with same-cycle bypass read
    regWrite = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
    set_rd(5, 5);
    chk("bypass_a", rd_a[DW-1:0], 32'hDEADBEEF);
    chk("nobypass_b", rd_b[DW-1:0], 32'h0);
    tick();
    regWrite = 1'b0;
    #1;
    chk("r5_p0_a", rd_a[DW-1:0], 32'hDEADBEEF);
    chk("r5_p1_a", rd_a[2*DW-1:DW], 32'hDEADBEEF);
    chk("r5_p1_b", rd_b[2*DW-1:DW], 32'hDEADBEEF);

    // 3. write to register 0
    regWrite = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
    set_rd(0, 0);
    chk("r0_bypass_a", rd_a[DW-1:0], 32'h0);
    tick();
    regWrite = 1'b0;
    #1;
    chk("r0_zero_a", rd_a[DW-1:0], 32'h0);
    chk("r0_err_a", err_a, 1'b0);
    chk("r0_b", rd_b[DW-1:0], 32'hFFFFFFFF);

    // 4. fill r1..r31, then clear with a mid-sweep re-request
    for (int i = 1; i < 32; i++) begin
      regWrite = 1'b1; write_reg = AW'(i); write_data = DW'(i);
      tick();
    end
    regWrite = 1'b0;
    set_rd(31, 1);
    chk("fill_r31", rd_a[DW-1:0], 32'd31);
    chk("fill_r1", rd_b[2*DW-1:DW], 32'd1);
    set_rd(17, 0);
    chk("fill_r17", rd_b[DW-1:0], 32'd17);
    chk("fill_r0_b", rd_b[2*DW-1:DW], 32'hFFFFFFFF);
    clear_req = 1'b1;
    #1;
    chk("busy_before_edge", busy_a, 1'b0);
    tick();
    clear_req = 1'b0;
    count_busy(cnt, 1'b1);
    chk("clear_sweep_len", cnt, 32);
    check_all_zero("post_clear_zero");

    // 5. write during sweep
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    regWrite = 1'b1; write_reg = 5'd7; write_data = 32'h1234;
    #1;
    chk("werr_not_yet", err_a, 1'b0);
    tick();
    regWrite = 1'b0;
    #1;
    chk("werr_pulse_a", err_a, 1'b1);
    chk("werr_pulse_b", err_b, 1'b1);
    tick();
    chk("werr_drop", err_a, 1'b0);
    count_busy(cnt, 1'b0);
    chk("sweep5_len", cnt, 30);
    set_rd(7, 7);
    chk("r7_a", rd_a[DW-1:0], 32'h0);
    chk("r7_b", rd_b[2*DW-1:DW], 32'h0);

    // 6. reset at sweep cycle 10
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("midsweep_busy", busy_a, 1'b1);
    reset = 1'b1;
    #1;
    chk("reset_mid_busy", busy_a, 1'b1);
    tick(); tick();
    reset = 1'b0;
    count_busy(cnt, 1'b0);
    chk("restart_sweep_len", cnt, 32);

    // write and clear request in the same idle cycle
    regWrite = 1'b1; write_reg = 5'd3; write_data = 32'h55;
    clear_req = 1'b1;
    tick();
    regWrite = 1'b0; clear_req = 1'b0;
    #1;
    chk("wr_clr_busy", busy_b, 1'b1);
    count_busy(cnt, 1'b0);
    chk("wr_clr_len", cnt, 32);
    set_rd(3, 3);
    chk("r3_a", rd_a[DW-1:0], 32'h0);
    chk("r3_b", rd_b[DW-1:0], 32'h0);
    chk("final_err", err_a, 1'b0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
